// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
// Request/acknowledge and external-bus signal bundle for mem_bus_arbiter.
//   master modport : drives the requests (req_addr, req_wr, req_en, ch_mask)
//                    and observes ack, grant and the bus outputs.
//   slave modport  : the arbiter side; samples requests, drives req_ack,
//                    grant, bus_addr, bus_wr, bus_ram_en, bus_map_en, busy.
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned ADDR_W = 16
);
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH-1:0]        req_wr;
   logic [NUM_CH-1:0]        req_en;
   logic [NUM_CH-1:0]        ch_mask;
   logic [NUM_CH-1:0]        req_ack;
   logic [NUM_CH-1:0]        grant;
   logic [ADDR_W-1:0]        bus_addr;
   logic                     bus_wr;
   logic                     bus_ram_en;
   logic                     bus_map_en;
   logic                     busy;

   modport master (
      output req_addr, req_wr, req_en, ch_mask,
      input  req_ack, grant, bus_addr, bus_wr, bus_ram_en, bus_map_en, busy
   );

   modport slave (
      input  req_addr, req_wr, req_en, ch_mask,
      output req_ack, grant, bus_addr, bus_wr, bus_ram_en, bus_map_en, busy
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Grants one of NUM_CH masters at a time, runs a registered bus access with
// RAM_WAIT extra cycles for SRAM (none for mapped registers) and returns a
// one-cycle req_ack in the final access cycle. An IDLE cycle always separates
// two accesses, so the bus is never enabled in IDLE.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : mem_bus_arbiter_if.slave (requests in; ack, grant, bus outputs out)
//
// Build option:
//   MEMARB_RR_EN defined   : round-robin, search starts after the last winner
//   MEMARB_RR_EN undefined : fixed priority, lowest eligible channel wins
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned       NUM_CH   = 3,
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] MAP_BASE = 16'hC000,
   parameter int unsigned       RAM_WAIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_arbiter_if.slave bus
);
   localparam int unsigned PW    = $clog2(NUM_CH);
   localparam int unsigned CNT_W = 4;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_q, wr_d;
   logic                ram_q, ram_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef MEMARB_RR_EN
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [PW-1:0]       idx;
`endif

   logic [NUM_CH-1:0]   elig;
   logic                found;
   logic [PW-1:0]       win_idx;
   logic [ADDR_W-1:0]   win_addr;
   logic                win_wr;

   assign elig = bus.req_en & bus.ch_mask;

   // Winner selection
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
`ifdef MEMARB_RR_EN
      idx = '0;
      // Rotated search: pointer+1, pointer+2, ... wrapping, pointer itself last
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = PW'((32'(ptr_q) + k) % NUM_CH);
         if (!found && elig[idx]) begin
            win_idx = idx;
            found   = 1'b1;
         end
      end
`else
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (!found && elig[k]) begin
            win_idx = PW'(k);
            found   = 1'b1;
         end
      end
`endif
      win_addr = '0;
      win_wr   = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (PW'(k) == win_idx) begin
            win_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
            win_wr   = bus.req_wr[k];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         ram_q   <= 1'b0;
         cnt_q   <= '0;
`ifdef MEMARB_RR_EN
         ptr_q   <= PW'(NUM_CH - 1);
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         ram_q   <= ram_d;
         cnt_q   <= cnt_d;
`ifdef MEMARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      ram_d   = ram_q;
      cnt_d   = cnt_q;
`ifdef MEMARB_RR_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d          = S_ACCESS;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               addr_d           = win_addr;
               wr_d             = win_wr;
               ram_d            = (win_addr < MAP_BASE);
               cnt_d            = (win_addr < MAP_BASE) ? CNT_W'(RAM_WAIT) : '0;
`ifdef MEMARB_RR_EN
               ptr_d            = win_idx;
`endif
            end
         end
         S_ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
               addr_d  = '0;
               wr_d    = 1'b0;
               ram_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: all derived from registered state
   always_comb begin
      bus.busy       = (state_q == S_ACCESS);
      bus.grant      = grant_q;
      bus.bus_addr   = addr_q;
      bus.bus_wr     = wr_q;
      bus.bus_ram_en = bus.busy & ram_q;
      bus.bus_map_en = bus.busy & ~ram_q;
      bus.req_ack    = (bus.busy && cnt_q == '0) ? grant_q : '0;
   end
endmodule
